// File: rtl/key_matrix_pkg.sv
// Shared types for the key matrix scanner: FSM states, per-frame scan result,
// and the key-code width helper.
package key_matrix_pkg;

    typedef enum logic [1:0] {SCAN, DEB, PRESSED, REL} scan_state_t;

    typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_res_t;

    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 2) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/key_row_sequencer.sv
// Row strobe generator: holds each row low for SCAN_DIV clocks, rotates one-hot
// active-low, and flags the last clock of each row dwell and of each frame.
module key_row_sequencer #(
    parameter  int ROWS     = 4,
    parameter  int SCAN_DIV = 1024,
    localparam int RW       = $clog2(ROWS),
    localparam int DW       = $clog2(SCAN_DIV)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [ROWS-1:0] row_n,
    output logic [RW-1:0]   row_idx,
    output logic            row_tick,
    output logic            frame_tick
);

    logic [DW-1:0] div_cnt;

    assign row_tick   = (div_cnt == DW'(SCAN_DIV - 1));
    assign frame_tick = row_tick && (row_idx == RW'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            row_idx <= '0;
            row_n   <= ~ROWS'(1);
        end else if (row_tick) begin
            div_cnt <= '0;
            row_idx <= frame_tick ? '0 : row_idx + RW'(1);
            row_n   <= {row_n[ROWS-2:0], row_n[ROWS-1]};
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/key_matrix_scanner.sv
// Row/column key matrix scanner with frame-level press/release debounce.
// Optional auto-repeat of key_valid while held: define KEY_MATRIX_AUTO_REPEAT_EN.
module key_matrix_scanner
    import key_matrix_pkg::*;
#(
    parameter  int ROWS            = 4,
    parameter  int COLS            = 4,
    parameter  int SCAN_DIV        = 1024,
    parameter  int DEBOUNCE_FRAMES = 4,
    parameter  int REPEAT_FRAMES   = 64,
    localparam int KW              = code_width(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col_n,
    output logic [ROWS-1:0] row_n,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(COLS);
    localparam int DCW = $clog2(DEBOUNCE_FRAMES + 1);

    if (ROWS < 2 || COLS < 2 || SCAN_DIV < 2 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_param
        $error("key_matrix_scanner: illegal parameter set");
    end

    logic [RW-1:0] row_idx;
    logic          row_tick, frame_tick;

    key_row_sequencer #(.ROWS(ROWS), .SCAN_DIV(SCAN_DIV)) u_seq (
        .clk        (clk),
        .rst        (rst),
        .row_n      (row_n),
        .row_idx    (row_idx),
        .row_tick   (row_tick),
        .frame_tick (frame_tick)
    );

    logic [COLS-1:0] col_meta, col_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= '1;
            col_s    <= '1;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

    logic [COLS-1:0] hit;
    logic            row_any, row_multi;
    logic [CW-1:0]   row_col;
    logic [KW-1:0]   row_code;

    assign hit       = ~col_s;
    assign row_any   = |hit;
    // Clearing the lowest set bit leaves something only if two or more keys share the row.
    assign row_multi = |(hit & (hit - COLS'(1)));
    assign row_code  = KW'(row_idx) * KW'(COLS) + KW'(row_col);

    always_comb begin
        row_col = '0;
        for (int c = COLS - 1; c >= 0; c--)
            if (hit[c]) row_col = CW'(c);
    end

    logic          acc_any, acc_multi;
    logic [KW-1:0] acc_code;
    logic          f_any, f_multi;
    logic [KW-1:0] f_code;
    frame_res_t    f_res;

    // Frame view including the row being sampled this cycle.
    assign f_any   = acc_any | row_any;
    assign f_multi = acc_multi | row_multi | (acc_any & row_any);
    assign f_code  = acc_any ? acc_code : row_code;
    assign f_res   = f_multi ? FR_MULTI : (f_any ? FR_SINGLE : FR_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_any   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= '0;
        end else if (frame_tick) begin
            acc_any   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= '0;
        end else if (row_tick) begin
            acc_any   <= f_any;
            acc_multi <= f_multi;
            acc_code  <= f_code;
        end
    end

    scan_state_t    state;
    logic [DCW-1:0] cnt;
    logic [KW-1:0]  cand;
`ifdef KEY_MATRIX_AUTO_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_FRAMES + 1);
    logic [RPW-1:0] rep_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEY_MATRIX_AUTO_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
`ifdef KEY_MATRIX_AUTO_REPEAT_EN
            // Held at zero outside PRESSED, so every entry starts a fresh repeat period.
            if (state != PRESSED) rep_cnt <= '0;
`endif
            if (frame_tick) begin
                case (state)
                    SCAN: if (f_res == FR_SINGLE) begin
                        cand <= f_code;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state     <= PRESSED;
                            key_code  <= f_code;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            state <= DEB;
                            cnt   <= DCW'(1);
                        end
                    end
                    DEB: if (f_res == FR_SINGLE && f_code == cand) begin
                        if (cnt + DCW'(1) == DCW'(DEBOUNCE_FRAMES)) begin
                            state     <= PRESSED;
                            key_code  <= cand;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + DCW'(1);
                        end
                    end else begin
                        state <= SCAN;
                        cnt   <= '0;
                    end
                    PRESSED: if (f_res == FR_NONE) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state    <= SCAN;
                            key_held <= 1'b0;
                        end else begin
                            state <= REL;
                            cnt   <= DCW'(1);
                        end
                    end
`ifdef KEY_MATRIX_AUTO_REPEAT_EN
                    else if (rep_cnt == RPW'(REPEAT_FRAMES - 1)) begin
                        rep_cnt   <= '0;
                        key_valid <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + RPW'(1);
                    end
`endif
                    REL: if (f_res == FR_NONE) begin
                        if (cnt + DCW'(1) == DCW'(DEBOUNCE_FRAMES)) begin
                            state    <= SCAN;
                            key_held <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + DCW'(1);
                        end
                    end else begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner: 4x4 matrix, SCAN_DIV=4, two-frame debounce (16 clk per frame).
module tb_key_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid, key_held;
    logic [15:0] keys = '0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses   = 0;
    int pulse_cyc[$];

`ifdef KEY_MATRIX_AUTO_REPEAT_EN
    localparam int RP = 1;
`else
    localparam int RP = 0;
`endif

    always #5 clk = ~clk;

    key_matrix_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .REPEAT_FRAMES(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Passive matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 4; r++)
            if (!row_n[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4 + c]) col_n[c] = 1'b0;
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst && key_valid) begin
            pulses++;
            pulse_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          exp_pulses;
        logic        exp_held;
        int          exp_code;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [3:0]  pat[4];
    int          p0, n0;

    initial begin
        pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        tbl.push_back('{16'h0000, 9, 0,  1'b0, 0,  "idle"});
        tbl.push_back('{16'h0200, 1, 0,  1'b0, 0,  "k9_f1"});
        tbl.push_back('{16'h0200, 1, 1,  1'b1, 9,  "k9_valid"});
        tbl.push_back('{16'h0200, 4, RP, 1'b1, 9,  "k9_hold"});
        tbl.push_back('{16'h0000, 1, 0,  1'b1, 9,  "k9_rel1"});
        tbl.push_back('{16'h0000, 1, 0,  1'b0, 9,  "k9_rel2"});
        tbl.push_back('{16'h1008, 4, 0,  1'b0, 9,  "multi_idle"});
        tbl.push_back('{16'h0000, 1, 0,  1'b0, 9,  "multi_rel"});
        tbl.push_back('{16'h0008, 2, 1,  1'b1, 3,  "k3_valid"});
        tbl.push_back('{16'h1008, 4, RP, 1'b1, 3,  "k3_plus12"});
        tbl.push_back('{16'h0000, 2, 0,  1'b0, 3,  "k3_rel"});
        tbl.push_back('{16'h8000, 2, 1,  1'b1, 15, "k15_valid"});
        tbl.push_back('{16'h0000, 1, 0,  1'b1, 15, "k15_gap"});
        tbl.push_back('{16'h8000, 2, 0,  1'b1, 15, "k15_repress"});
        tbl.push_back('{16'h0000, 2, 0,  1'b0, 15, "k15_rel"});
        tbl.push_back('{16'h0003, 3, 0,  1'b0, 15, "same_row_multi"});
        tbl.push_back('{16'h0040, 1, 0,  1'b0, 15, "k6_f1"});
        tbl.push_back('{16'h0400, 1, 0,  1'b0, 15, "k10_other"});
        tbl.push_back('{16'h0040, 1, 0,  1'b0, 15, "k6_restart"});
        tbl.push_back('{16'h0040, 1, 1,  1'b1, 6,  "k6_valid"});
        tbl.push_back('{16'h0000, 2, 0,  1'b0, 6,  "k6_rel"});

        rst = 1'b1;
        tick(3);
        check("rst_row_n", row_n, 4'b1110);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_held", key_held, 0);
        rst = 1'b0;

        for (int k = 1; k <= 16; k++) begin
            tick(1);
            check($sformatf("row_n_edge%0d", k), row_n, pat[(k / 4) % 4]);
        end

        foreach (tbl[i]) begin
            keys = tbl[i].keys;
            p0   = pulses;
            tick(tbl[i].frames * 16);
            check({tbl[i].name, "_pulses"}, pulses - p0, tbl[i].exp_pulses);
            check({tbl[i].name, "_held"}, key_held, tbl[i].exp_held);
            check({tbl[i].name, "_code"}, key_code, tbl[i].exp_code);
        end

        // Bounce: key 5 present one frame, absent the next, five times.
        p0 = pulses;
        for (int b = 0; b < 5; b++) begin
            keys = 16'h0020;
            tick(16);
            keys = 16'h0000;
            tick(16);
        end
        check("bounce_pulses", pulses - p0, 0);
        check("bounce_held", key_held, 0);

        // Reset in the middle of debouncing key 7, key still held afterwards.
        keys = 16'h0080;
        tick(16 + 5);
        rst = 1'b1;
        #1;
        check("midrst_key_code", key_code, 0);
        check("midrst_row_n", row_n, 4'b1110);
        check("midrst_key_held", key_held, 0);
        check("midrst_key_valid", key_valid, 0);
        tick(2);
        rst = 1'b0;
        p0 = pulses;
        tick(16);
        check("postrst_f1_pulses", pulses - p0, 0);
        tick(16);
        check("postrst_f2_pulses", pulses - p0, 1);
        check("postrst_code", key_code, 7);
        check("postrst_held", key_held, 1);
        keys = 16'h0000;
        tick(32);
        check("postrst_rel_held", key_held, 0);

        // Long hold of key 0: repeat pulses only with the auto-repeat build.
        keys = 16'h0001;
        p0 = pulses;
        tick(32);
        check("k0_valid", pulses - p0, 1);
        check("k0_code", key_code, 0);
        p0 = pulses;
        n0 = pulse_cyc.size();
        tick(12 * 16);
`ifdef KEY_MATRIX_AUTO_REPEAT_EN
        check("repeat_pulses", pulses - p0, 4);
        if (pulse_cyc.size() >= n0 + 4) begin
            for (int j = 1; j < 4; j++)
                check($sformatf("repeat_gap%0d", j), pulse_cyc[n0 + j] - pulse_cyc[n0 + j - 1], 48);
        end else begin
            check("repeat_gap_count", pulse_cyc.size() - n0, 4);
        end
`else
        check("no_repeat_pulses", pulses - p0, 0);
`endif
        check("k0_hold_code", key_code, 0);
        check("k0_hold_held", key_held, 1);
        keys = 16'h0000;
        tick(32);
        check("k0_rel_held", key_held, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
